// File: rtl/vga_timing_pkg.sv
// Shared raster timing types, standard mode constants and the total() helper
// used by the parametrised VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_t;

  localparam axis_t VGA640_H  = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam axis_t VGA640_V  = '{active: 480, fp: 10, sync: 2,   bp: 33};
  localparam axis_t SVGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_t SVGA800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

  localparam int unsigned MAX_LAT = 8;

  function automatic int unsigned total(axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of DEPTH stages; DEPTH 0 is a plain wire.
// Reset clears every stage to zero, which the top treats as "inactive".
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stage <= '0;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_param.sv
// Parametrised raster timing generator: presents (h, v) upstream, realigns
// the returned pixel with LAT-delayed sync/active terms at the output pins.
module vga_timing_param
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int RGB_W     = 12,
  parameter int LAT       = 0,
  parameter int CW        = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  input  logic             en,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CW-1:0]    h,
  output logic [CW-1:0]    v,
  output logic             hsync,
  output logic             vsync,
  output logic             vidstate,
  output logic [RGB_W-1:0] rgb_out,
  output logic             line_start,
  output logic             frame_start
);

  localparam axis_t H_CFG = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam axis_t V_CFG = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned H_TOTAL = total(H_CFG);
  localparam int unsigned V_TOTAL = total(V_CFG);
  localparam int unsigned H_HS_BEG = H_CFG.active + H_CFG.fp;
  localparam int unsigned H_HS_END = H_HS_BEG + H_CFG.sync;
  localparam int unsigned V_VS_BEG = V_CFG.active + V_CFG.fp;
  localparam int unsigned V_VS_END = V_VS_BEG + V_CFG.sync;
  localparam int unsigned MAX_TOT  = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  if (CW < 1 || CW > 31 || (64'd1 << CW) < 64'(MAX_TOT)) begin : g_bad_cw
    $error("vga_timing_param: CW too small for H_TOTAL/V_TOTAL");
  end
  if (LAT < 0 || LAT > int'(MAX_LAT)) begin : g_bad_lat
    $error("vga_timing_param: LAT must be 0..8");
  end
  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $error("vga_timing_param: sync width must be nonzero");
  end

  int unsigned hx, vx;
  logic        h_last, v_last;
  logic        act, hs, vs;
  logic [2:0]  pipe_in, pipe_out;

  assign hx     = 32'(h);
  assign vx     = 32'(v);
  assign h_last = (hx == H_TOTAL - 1);
  assign v_last = (vx == V_TOTAL - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_ce) begin
      if (!en) begin
        h <= '0;
        v <= '0;
      end else if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Pure compares against the live counters; no decoded state to drift.
  assign act = (hx < H_CFG.active) && (vx < V_CFG.active);
  assign hs  = (hx >= H_HS_BEG) && (hx < H_HS_END);
  assign vs  = (vx >= V_VS_BEG) && (vx < V_VS_END);

  // Stopped raster feeds idle terms so the pins drain to blank.
  assign pipe_in = en ? {act, hs, vs} : 3'b000;

  vga_delay_line #(.WIDTH(3), .DEPTH(LAT)) u_dly (
    .clk (clk),
    .rst (rst),
    .ce  (pix_ce),
    .d   (pipe_in),
    .q   (pipe_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vidstate <= 1'b0;
      hsync    <= ~HS_ON;
      vsync    <= ~VS_ON;
      rgb_out  <= '0;
    end else if (pix_ce) begin
      vidstate <= pipe_out[2];
      hsync    <= pipe_out[1] ? HS_ON : ~HS_ON;
      vsync    <= pipe_out[0] ? VS_ON : ~VS_ON;
      rgb_out  <= pipe_out[2] ? rgb_in : '0;
    end
  end

  // Gated by rst so the strobes stay quiet while held in reset at (0,0).
  assign line_start  = rst && pix_ce && en && (h == '0);
  assign frame_start = line_start && (v == '0);

endmodule

// File: tb/tb_vga_timing_param.sv
// Lock-step bench: four generator configurations driven together and checked
// every clock against a linear-position reference model.
module tb_vga_timing_param;
  import vga_timing_pkg::*;

  localparam int NDUT = 4;
  localparam int CW   = 11;
  localparam int RW   = 12;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int lat; int hpol; int vpol;
  } cfg_t;

  function automatic cfg_t cfg_of(int i);
    case (i)
      0: return '{ha: 8, hf: 2, hs: 3, hb: 2, va: 5, vf: 1, vs: 2, vb: 2,
                  lat: 0, hpol: 0, vpol: 0};
      1: return '{ha: 10, hf: 3, hs: 4, hb: 3, va: 4, vf: 2, vs: 1, vb: 3,
                  lat: 2, hpol: 0, vpol: 1};
      2: return '{ha: int'(SVGA800_H.active), hf: int'(SVGA800_H.fp),
                  hs: int'(SVGA800_H.sync), hb: int'(SVGA800_H.bp),
                  va: 3, vf: 1, vs: 1, vb: 1, lat: 1, hpol: 1, vpol: 1};
      default: return '{ha: 4, hf: 1, hs: 1, hb: 1,
                  va: int'(SVGA800_V.active), vf: int'(SVGA800_V.fp),
                  vs: int'(SVGA800_V.sync), vb: int'(SVGA800_V.bp),
                  lat: 8, hpol: 1, vpol: 1};
    endcase
  endfunction

  logic clk, rst, pix_ce, en;
  logic [RW-1:0] rgb   [NDUT];
  logic [CW-1:0] h_o   [NDUT];
  logic [CW-1:0] v_o   [NDUT];
  logic          hs_o  [NDUT];
  logic          vs_o  [NDUT];
  logic          vid_o [NDUT];
  logic [RW-1:0] rgb_o [NDUT];
  logic          ls_o  [NDUT];
  logic          fs_o  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam cfg_t C = cfg_of(g);
    vga_timing_param #(
      .H_ACTIVE(C.ha), .H_FP(C.hf), .H_SYNC(C.hs), .H_BP(C.hb),
      .V_ACTIVE(C.va), .V_FP(C.vf), .V_SYNC(C.vs), .V_BP(C.vb),
      .HSYNC_POL(C.hpol), .VSYNC_POL(C.vpol), .RGB_W(RW), .LAT(C.lat), .CW(CW)
    ) dut (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en), .rgb_in(rgb[g]),
      .h(h_o[g]), .v(v_o[g]), .hsync(hs_o[g]), .vsync(vs_o[g]),
      .vidstate(vid_o[g]), .rgb_out(rgb_o[g]),
      .line_start(ls_o[g]), .frame_start(fs_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raster as a single linear pixel index per configuration.
  int            pos  [NDUT];
  int            pipe [NDUT][8];
  logic [2:0]    pin  [NDUT];
  logic [RW-1:0] prgb [NDUT];

  int total, bad;
  int steps, clks;
  bit meas, gap, vid_win;
  int rise_c, rise_d, vid_cnt, ls_last;
  logic prev_hs_c, prev_vs_d, prev_vs_a;

  function automatic int htot(cfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
  function automatic int vtot(cfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction

  function automatic logic [2:0] terms(cfg_t c, int p);
    int hh, vv, ht;
    if (p < 0) return 3'b000;
    ht = htot(c);
    hh = p % ht;
    vv = p / ht;
    return {hh < c.ha && vv < c.va,
            hh >= c.ha + c.hf && hh < c.ha + c.hf + c.hs,
            vv >= c.va + c.vf && vv < c.va + c.vf + c.vs};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      pos[i] = 0;
      pin[i] = 3'b000;
      prgb[i] = '0;
      for (int k = 0; k < 8; k++) pipe[i][k] = -1;
    end
  endtask

  task automatic model_step(input int i, input logic e, input logic [RW-1:0] r);
    cfg_t c;
    int pres, outp;
    c = cfg_of(i);
    pres = e ? pos[i] : -1;
    pos[i] = e ? (pos[i] + 1) % (htot(c) * vtot(c)) : 0;
    if (c.lat == 0) outp = pres;
    else begin
      outp = pipe[i][c.lat-1];
      for (int k = c.lat - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
      pipe[i][0] = pres;
    end
    pin[i]  = terms(c, outp);
    prgb[i] = pin[i][2] ? r : '0;
  endtask

  function automatic logic [38:0] expect_vec(int i);
    cfg_t c;
    int hh, vv;
    logic ls, fs, hp, vp;
    c  = cfg_of(i);
    hh = pos[i] % htot(c);
    vv = pos[i] / htot(c);
    ls = rst && pix_ce && en && hh == 0;
    fs = ls && vv == 0;
    hp = (c.hpol != 0);
    vp = (c.vpol != 0);
    return {11'(hh), 11'(vv), pin[i][1] ? hp : ~hp, pin[i][0] ? vp : ~vp,
            pin[i][2], prgb[i], ls, fs};
  endfunction

  task automatic chk_all(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      logic [38:0] g, e;
      g = {h_o[i], v_o[i], hs_o[i], vs_o[i], vid_o[i], rgb_o[i], ls_o[i], fs_o[i]};
      e = expect_vec(i);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s dut%0d @%0t got h=%0d v=%0d hs=%b vs=%b vid=%b rgb=%h ls=%b fs=%b want h=%0d v=%0d hs=%b vs=%b vid=%b rgb=%h ls=%b fs=%b",
                 tag, i, $time, g[38:28], g[27:17], g[16], g[15], g[14], g[13:2], g[1], g[0],
                 e[38:28], e[27:17], e[16], e[15], e[14], e[13:2], e[1], e[0]);
      end
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", tag, got, want, $time);
    end
  endtask

  // One clock: drive, step model on the edge, check every configuration.
  task automatic cyc(input logic ce, input logic e, input string tag);
    pix_ce = ce;
    en     = e;
    for (int i = 0; i < NDUT; i++) rgb[i] = RW'($urandom);
    @(posedge clk);
    if (rst && ce) begin
      for (int i = 0; i < NDUT; i++) model_step(i, e, rgb[i]);
      steps++;
    end
    #1;
    chk_all(tag);
    clks++;
    if (meas) begin
      if (hs_o[2] && !prev_hs_c) begin
        if (rise_c >= 0) chk_int("svga_line_steps", steps - rise_c, 1056);
        rise_c = steps;
      end
      if (vs_o[3] && !prev_vs_d) begin
        if (rise_d >= 0) chk_int("svga_frame_steps", steps - rise_d, 628 * 7);
        rise_d = steps;
      end
      if (ce && vid_o[0]) vid_cnt++;
      if (!vs_o[0] && prev_vs_a) begin
        if (vid_win) chk_int("active_per_frame", vid_cnt, 8 * 5);
        vid_win = 1;
        vid_cnt = 0;
      end
    end
    if (gap && ls_o[0]) begin
      if (ls_last >= 0) chk_int("ce4_line_clks", clks - ls_last, 4 * 15);
      ls_last = clks;
    end
    prev_hs_c = hs_o[2];
    prev_vs_d = vs_o[3];
    prev_vs_a = vs_o[0];
  endtask

  initial begin
    total = 0; bad = 0; steps = 0; clks = 0;
    meas = 0; gap = 0; vid_win = 0;
    rise_c = -1; rise_d = -1; vid_cnt = 0; ls_last = -1;
    prev_hs_c = 1'b0; prev_vs_d = 1'b0; prev_vs_a = 1'b1;
    pix_ce = 1'b0; en = 1'b0;
    for (int i = 0; i < NDUT; i++) rgb[i] = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();

    // Held in reset with pix_ce/en high: idle pins, no strobes.
    repeat (3) cyc(1'b1, 1'b1, "por_hold");
    #2 rst = 1'b1;
    #1 chk_all("por_release");

    // Free-running frames, all configurations.
    meas = 1;
    repeat (9000) cyc(1'b1, 1'b1, "run");
    meas = 0;

    // pix_ce every fourth clock, then arbitrary duty.
    gap = 1;
    for (int k = 0; k < 1200; k++) cyc(1'(k % 4 == 3), 1'b1, "ce4");
    gap = 0;
    repeat (500) cyc(1'($urandom_range(0, 1)), 1'b1, "ce_rand");

    // Run enable dropped mid-line for 50 steps, with some idle clocks.
    repeat (7) cyc(1'b1, 1'b1, "pre_en");
    repeat (50) cyc(1'b1, 1'b0, "en_low");
    repeat (5) cyc(1'b0, 1'b0, "en_low_hold");
    pix_ce = 1'b1; en = 1'b1;
    #1 chk_all("en_rise");
    repeat (400) cyc(1'b1, 1'b1, "en_run");

    // Asynchronous reset mid-frame, checked before the next edge.
    repeat (1300) cyc(1'b1, 1'b1, "pre_rst");
    #2 rst = 1'b0;
    model_reset();
    #1 chk_all("async_rst");
    repeat (2) cyc(1'b1, 1'b1, "rst_hold");
    #2 rst = 1'b1;
    #1 chk_all("rst_release");
    repeat (300) cyc(1'b1, 1'b1, "post_rst");
    repeat (200) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), "mix");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
